// File: rtl/ysyx_220053_pipe_pkg.sv
// Shared constants for the ysyx_220053 elastic pipeline registers.
// Stage state encoding and default payload widths live here so every stage agrees on them.
package ysyx_220053_pipe_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int OCC_W   = 2;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ysyx_220053_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Shared by the core's performance counters.
module ysyx_220053_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_220053_pipe_skid_reg.sv
// Valid/ready inter-stage register with an optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module ysyx_220053_pipe_skid_reg
  import ysyx_220053_pipe_pkg::*;
#(
  parameter int DATA_W     = PC_W + INSTR_W,
  parameter int SKID       = 1,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit SKID_EN  = (SKID != 0);
  localparam bit ZERO_EN  = (FLUSH_ZERO != 0);

  pipe_state_e       state_q, state_n;
  logic [DATA_W-1:0] main_q, main_n;
  logic [DATA_W-1:0] skid_q, skid_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
    end
  end

  // With the skid buffer in_ready depends on state only, so the stall chain is cut here.
  generate
    if (SKID_EN) begin : g_skid_ready
      assign in_ready = (state_q != PS_FULL);
    end else begin : g_plain_ready
      assign in_ready = rst_n ? ((state_q == PS_EMPTY) || out_ready) : out_ready;
    end
  endgenerate

  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state_q)
      PS_EMPTY: begin
        if (in_valid && in_ready) begin
          state_n = PS_BUSY;
          main_n  = in_data;
        end
      end
      PS_BUSY: begin
        if (in_valid && out_ready) begin
          main_n = in_data;
        end else if (in_valid && SKID_EN) begin
          state_n = PS_FULL;
          skid_n  = in_data;
        end else if (out_ready) begin
          state_n = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (out_ready) begin
          state_n = PS_BUSY;
          main_n  = skid_q;
        end
      end
      default: begin
        state_n = PS_EMPTY;
      end
    endcase

    // Flush discards any same-cycle upstream offer; payloads are either zeroed or left untouched.
    if (flush) begin
      state_n = PS_EMPTY;
      if (ZERO_EN) begin
        main_n = '0;
        skid_n = '0;
      end else begin
        main_n = main_q;
        skid_n = skid_q;
      end
    end
  end

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign occupancy = OCC_W'(state_q);

  ysyx_220053_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stall_clr),
    .inc   (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: doc/ysyx_220053_pipe_skid_reg.md
Name: ysyx_220053_pipe_skid_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the ysyx_220053 core, replacing the per-stage enable/flush registers with a valid/ready elastic handshake.
- Carries one opaque payload bus per stage: pc, instr and control fields, packed by the instantiating stage.
- An optional 2-entry skid buffer lets in_ready be registered, breaking the combinational stall chain between stages.
- Includes a saturating back-pressure counter for performance analysis.

Parameters:
DATA_W, 96, payload width in bits (default = 64-bit pc + 32-bit instr)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
FLUSH_ZERO, 1, 1 = flush also clears payload registers to 0; 0 = flush clears valid state only
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a live entry
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DATA_W  oldest held payload
occupancy  output  2  entries held (0..2; max 1 when SKID=0)
stall_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Transfers:
  - Upstream transfer when in_valid & in_ready.
  - Downstream transfer when out_valid & out_ready.
  - Order is strictly FIFO; no payload is duplicated or dropped except by flush.
- Reset (rst_n=0, asynchronous): state EMPTY, main and skid payloads = 0, out_valid=0, occupancy=0, stall_cnt=0.
  - in_ready=1 for SKID=1; in_ready=out_ready for SKID=0.
  - Reset asserted mid-transfer discards everything immediately.
- Latency: 1 cycle. Data accepted at edge N appears on out_data after edge N when the stage was empty or draining.
- SKID=1 state machine (in_ready = state!=FULL, registered):
  - EMPTY: in_valid → BUSY, main<=in_data.
  - BUSY:
    - in_valid & out_ready → BUSY, main<=in_data.
    - in_valid & !out_ready → FULL, skid<=in_data.
    - !in_valid & out_ready → EMPTY.
    - Otherwise hold.
  - FULL: out_ready → BUSY, main<=skid. No upstream accept (in_ready=0).
  - out_valid = state!=EMPTY; out_data = main; occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- SKID=0: single register.
  - in_ready = !out_valid | out_ready.
  - On upstream transfer, main<=in_data and out_valid<=1.
  - On downstream-only transfer, out_valid<=0.
- flush (highest priority after reset):
  - Next state EMPTY, out_valid<=0, occupancy<=0.
  - An upstream offer in the same cycle is discarded, even though in_ready may read 1.
  - A downstream transfer in the same cycle still counts as completed for the consumer.
  - With FLUSH_ZERO=1, main and skid are zeroed; with FLUSH_ZERO=0, payloads are held but never presented.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment and sets the counter to 0.
  - Flush does not clear it.
- Payload registers are written only on the transitions listed. No X is propagated: all payload flops are reset.

Decomposition:
- Shared package ysyx_220053_pipe_pkg:
  - State encoding constants PS_EMPTY=2'd0, PS_BUSY=2'd1, PS_FULL=2'd2.
  - Default widths PC_W=64, INSTR_W=32.
  - Occupancy width constant.
- One natural sub-module: ysyx_220053_sat_cnt (parametrised saturating counter with clear/inc), reused by other performance counters.
- Payload packing stays in the instantiating stage.

Test Plan:
1. Reset, then in_valid=1 with data 0x1, 0x2, 0x3 on consecutive cycles and out_ready=1 → out_data 0x1, 0x2, 0x3 one cycle later each, occupancy stays 1, stall_cnt=0.
2. SKID=1: feed 0xA, 0xB with out_ready=0 → occupancy 2, in_ready=0 on the third cycle, stall_cnt counts 1, 2, ...; release out_ready → 0xA then 0xB, and in_ready returns to 1 one cycle after the first drain.
3. FULL state with flush=1 and in_valid=1 data 0xC → next cycle out_valid=0, occupancy=0, 0xC never emerges; with FLUSH_ZERO=1, internal main/skid read 0.
4. SKID=0: out_valid=1, out_ready=0 → in_ready=0; assert out_ready with in_valid data 0x5 → in_ready=1 in the same cycle and 0x5 appears next cycle.
5. CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 15; stall_clr for one cycle → 0, then resumes counting at 1.
6. Assert rst_n=0 asynchronously mid-cycle while FULL → out_valid, occupancy and stall_cnt drop to 0 before the next clock edge; after release the first accepted datum 0x7 emerges normally.
